// File: rtl/exec_sequencer.sv
// Multicycle operand-fetch/execute sequencer: register file, A/B operand
// registers, B-path shifter, ALU drive, result capture and writeback.
module exec_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic [1:0]  op,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [2:0]  rd,
  input  logic [1:0]  shift,
  input  logic        asel,
  input  logic        bsel,
  input  logic [4:0]  imm5,
  input  logic        wb_en,
  input  logic        ld,
  input  logic [15:0] ld_data,
  output logic [15:0] Ain,
  output logic [15:0] Bin,
  output logic [1:0]  ALUop,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  output logic [15:0] C,
  output logic        Z_flag,
  output logic        done
);

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] a_q, b_q, b_shift;

  logic [1:0] cmd_op;
  logic [2:0] cmd_rn, cmd_rm, cmd_rd;
  logic [1:0] cmd_shift;
  logic       cmd_asel, cmd_bsel, cmd_wb_en;
  logic [4:0] cmd_imm5;

  logic cap_c, ld_we_c, a_we_c, b_we_c, c_we_c, wb_we_c;

  // State register with registered ready/done derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == S_IDLE);
      done  <= (state_nx == S_WB);
    end
  end

  // Next-state and datapath enables
  always_comb begin
    state_nx = state;
    cap_c    = 1'b0;
    ld_we_c  = 1'b0;
    a_we_c   = 1'b0;
    b_we_c   = 1'b0;
    c_we_c   = 1'b0;
    wb_we_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cap_c    = 1'b1;
          state_nx = S_RDA;
        end else if (ld) begin
          ld_we_c = 1'b1;
        end
      end
      S_RDA: begin
        a_we_c   = 1'b1;
        state_nx = S_RDB;
      end
      S_RDB: begin
        b_we_c   = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        c_we_c   = 1'b1;
        state_nx = S_WB;
      end
      S_WB: begin
        wb_we_c  = cmd_wb_en;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Command capture, operand registers, result/flag and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_op    <= 2'd0;
      cmd_rn    <= 3'd0;
      cmd_rm    <= 3'd0;
      cmd_rd    <= 3'd0;
      cmd_shift <= 2'd0;
      cmd_asel  <= 1'b0;
      cmd_bsel  <= 1'b0;
      cmd_imm5  <= 5'd0;
      cmd_wb_en <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      C         <= '0;
      Z_flag    <= 1'b0;
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else begin
      if (cap_c) begin
        cmd_op    <= op;
        cmd_rn    <= rn;
        cmd_rm    <= rm;
        cmd_rd    <= rd;
        cmd_shift <= shift;
        cmd_asel  <= asel;
        cmd_bsel  <= bsel;
        cmd_imm5  <= imm5;
        cmd_wb_en <= wb_en;
      end
      if (a_we_c) a_q <= regs[cmd_rn];
      if (b_we_c) b_q <= regs[cmd_rm];
      if (c_we_c) begin
        C      <= alu_out;
        Z_flag <= alu_z;
      end
      if (ld_we_c)      regs[rd]     <= ld_data;
      else if (wb_we_c) regs[cmd_rd] <= C;
    end
  end

  // B-path shifter; ASR1 keeps the sign bit
  always_comb begin
    b_shift = b_q;
    case (cmd_shift)
      2'b01:   b_shift = {b_q[DW-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[DW-1:1]};
      2'b11:   b_shift = {b_q[DW-1], b_q[DW-1:1]};
      default: b_shift = b_q;
    endcase
  end

  assign Ain   = cmd_asel ? '0 : a_q;
  assign Bin   = cmd_bsel ? DW'(cmd_imm5) : b_shift;
  assign ALUop = cmd_op;

endmodule

// File: tb/tb_exec_sequencer.sv
// Table-driven bench for exec_sequencer with a behavioural ALU in the loop
// and hand-written sequences for busy-time inputs and mid-operation reset.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, ready;
  logic [1:0]  op;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  shift;
  logic        asel, bsel, wb_en, ld;
  logic [4:0]  imm5;
  logic [15:0] ld_data, Ain, Bin, alu_out, C;
  logic [1:0]  ALUop;
  logic        alu_z, Z_flag, done;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  exec_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .op(op), .rn(rn), .rm(rm), .rd(rd), .shift(shift),
    .asel(asel), .bsel(bsel), .imm5(imm5), .wb_en(wb_en),
    .ld(ld), .ld_data(ld_data),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop),
    .alu_out(alu_out), .alu_z(alu_z),
    .C(C), .Z_flag(Z_flag), .done(done)
  );

  always #5 clk = ~clk;

  // ALU: 00 ADD, 01 SUB, 10 AND, 11 MVN
  always_comb begin
    case (ALUop)
      2'b00:   alu_out = Ain + Bin;
      2'b01:   alu_out = Ain - Bin;
      2'b10:   alu_out = Ain & Bin;
      default: alu_out = ~Bin;
    endcase
    alu_z = (alu_out == 16'd0);
  end

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rn, rm, rd;
    logic [1:0]  shift;
    logic        asel, bsel;
    logic [4:0]  imm5;
    logic        wb_en, ld;
    logic [15:0] ld_data;
    logic [15:0] exp_bin, exp_c;
    logic        exp_z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mkv(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] d, input logic [1:0] s, input logic as,
                               input logic bs, input logic [4:0] im, input logic wb,
                               input logic l, input logic [15:0] ldd, input logic [15:0] eb,
                               input logic [15:0] ec, input logic ez);
    vec_t v;
    v.op = o; v.rn = a; v.rm = b; v.rd = d; v.shift = s; v.asel = as; v.bsel = bs;
    v.imm5 = im; v.wb_en = wb; v.ld = l; v.ld_data = ldd;
    v.exp_bin = eb; v.exp_c = ec; v.exp_z = ez;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; rn = v.rn; rm = v.rm; rd = v.rd; shift = v.shift;
    asel = v.asel; bsel = v.bsel; imm5 = v.imm5; wb_en = v.wb_en;
    ld = v.ld; ld_data = v.ld_data;
  endtask

  task automatic do_ld(input logic [2:0] r, input logic [15:0] d);
    @(negedge clk);
    start = 1'b0; ld = 1'b1; rd = r; ld_data = d;
  endtask

  // Full command with cycle-exact checks; start sampled at edge t0
  task automatic run_cmd(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; ld = 1'b0;
    chk({nm, " ready_busy"}, 16'(ready), 16'd0);
    @(posedge clk);
    @(posedge clk); #1;
    chk({nm, " Bin"}, Bin, v.exp_bin);
    chk({nm, " ALUop"}, 16'(ALUop), 16'(v.op));
    @(posedge clk); #1;
    chk({nm, " done"}, 16'(done), 16'd1);
    chk({nm, " C"}, C, v.exp_c);
    chk({nm, " Z"}, 16'(Z_flag), 16'(v.exp_z));
    @(posedge clk); #1;
    chk({nm, " done_end"}, 16'(done), 16'd0);
    chk({nm, " ready_end"}, 16'(ready), 16'd1);
  endtask

  initial begin
    vec_t v;
    int   bad;
    reset = 1'b1; start = 1'b0; ld = 1'b0; ld_data = '0;
    op = '0; rn = '0; rm = '0; rd = '0; shift = '0;
    asel = 1'b0; bsel = 1'b0; imm5 = '0; wb_en = 1'b0;

    //             op    rn    rm    rd    sh    as    bs    imm     wb    ld    ldd       bin       c         z
    vecs[0]  = mkv(2'd0, 3'd0, 3'd1, 3'd2, 2'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 16'd0,    16'd7,    16'd12,   1'b0);
    vecs[1]  = mkv(2'd0, 3'd0, 3'd2, 3'd0, 2'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'd12,   16'd12,   1'b0);
    vecs[2]  = mkv(2'd1, 3'd3, 3'd4, 3'd0, 2'd1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'd6,    16'd4,    1'b0);
    vecs[3]  = mkv(2'd2, 3'd5, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 16'd0,    16'd12,   16'd12,   1'b0);
    vecs[4]  = mkv(2'd3, 3'd0, 3'd7, 3'd0, 2'd3, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'hC000, 16'h3FFF, 1'b0);
    vecs[5]  = mkv(2'd1, 3'd6, 3'd6, 3'd6, 2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'd45,   16'd0,    1'b1);
    vecs[6]  = mkv(2'd0, 3'd0, 3'd6, 3'd0, 2'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'd45,   16'd45,   1'b0);
    vecs[7]  = mkv(2'd0, 3'd0, 3'd7, 3'd0, 2'd2, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'h4000, 16'h4000, 1'b0);
    vecs[8]  = mkv(2'd0, 3'd0, 3'd5, 3'd5, 2'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 16'd1234, 16'd15,   16'd15,   1'b0);
    vecs[9]  = mkv(2'd0, 3'd0, 3'd5, 3'd0, 2'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'd15,   16'd15,   1'b0);
    vecs[10] = mkv(2'd0, 3'd1, 3'd1, 3'd1, 2'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 16'd0,    16'd7,    16'd14,   1'b0);
    vecs[11] = mkv(2'd0, 3'd0, 3'd1, 3'd0, 2'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 16'd0,    16'd14,   16'd14,   1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst ready", 16'(ready), 16'd1);
    chk("rst done", 16'(done), 16'd0);
    chk("rst C", C, 16'd0);
    chk("rst Z", 16'(Z_flag), 16'd0);
    chk("rst Ain", Ain, 16'd0);
    chk("rst Bin", Bin, 16'd0);
    chk("rst ALUop", 16'(ALUop), 16'd0);

    // R1 is loaded last so the first command reads a value written one edge earlier
    do_ld(3'd0, 16'd5);
    do_ld(3'd3, 16'd10);
    do_ld(3'd4, 16'd3);
    do_ld(3'd5, 16'd15);
    do_ld(3'd6, 16'd45);
    do_ld(3'd7, 16'h8000);
    do_ld(3'd1, 16'd7);

    for (int i = 0; i < 12; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // start/ld pulsed while busy in RDB must not disturb the command or R1
    v = mkv(2'd0, 3'd0, 3'd1, 3'd2, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 16'd14, 16'd14, 1'b0);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; ld = 1'b1; rd = 3'd1; ld_data = 16'd999;
    op = 2'd3; bsel = 1'b1; imm5 = 5'd31;
    @(posedge clk);
    #1 start = 1'b0; ld = 1'b0;
    chk("busy Bin", Bin, 16'd14);
    chk("busy ALUop", 16'(ALUop), 16'd0);
    @(posedge clk); #1;
    chk("busy done", 16'(done), 16'd1);
    chk("busy C", C, 16'd14);
    @(posedge clk); #1;
    chk("busy ready", 16'(ready), 16'd1);
    run_cmd(vecs[11], "busy R1");

    // Reset in EXEC: immediate abort, no writeback, no done afterwards
    v = mkv(2'd0, 3'd0, 3'd1, 3'd3, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre-rst C", C, 16'd14);
    reset = 1'b1;
    #1;
    chk("mid-rst ready", 16'(ready), 16'd1);
    chk("mid-rst done", 16'(done), 16'd0);
    chk("mid-rst C", C, 16'd0);
    chk("mid-rst Z", 16'(Z_flag), 16'd0);
    chk("mid-rst Ain", Ain, 16'd0);
    @(negedge clk) reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("post-rst quiet", 16'(bad), 16'd0);
    v = mkv(2'd0, 3'd0, 3'd3, 3'd0, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
    run_cmd(v, "post-rst R3");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multicycle operand-fetch and execute sequencer for the 16-bit datapath. It sits directly upstream of the ALU. It holds the 8-entry register file, the A/B operand registers and the B-path shifter, and drives the ALU's Ain/Bin/ALUop inputs. It captures the ALU result into register C and the Z status flag, then optionally writes C back to the register file, all under a start/done handshake.

## Interface
- No parameters. Data width is fixed at 16 bits. Register count is fixed at 8, indexed by 3 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command request, sampled only when ready=1.
- ready  out  1  high in IDLE.
- op  in  2  ALU operation, passed through as ALUop.
- rn  in  3  index of the A-operand register.
- rm  in  3  index of the B-operand register.
- rd  in  3  destination index, used for writeback and for ld.
- shift  in  2  B-path shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1.
- asel  in  1  1: Ain = 16'd0.
- bsel  in  1  1: Bin = {11'b0, imm5}, and the shifter is bypassed.
- imm5  in  5  immediate for bsel.
- wb_en  in  1  1: write C to R[rd] in state WB.
- ld  in  1  direct register load request, honoured only in IDLE.
- ld_data  in  16  value for ld.
- Ain  out  16  to ALU: asel ? 0 : A.
- Bin  out  16  to ALU: bsel ? imm : shift(B).
- ALUop  out  2  to ALU: latched op.
- alu_out  in  16  ALU result.
- alu_z  in  1  ALU zero flag.
- C  out  16  result register.
- Z_flag  out  1  status register.
- done  out  1  one-cycle completion pulse.

## Operation
- Command capture:
  - In IDLE, start=1 latches op, rn, rm, rd, shift, asel, bsel, imm5 and wb_en into internal command registers.
  - These fields are ignored in every other state.
- FSM states:
  - IDLE: ready=1. start → RDA. ld=1 with start=0 writes R[rd] <= ld_data and stays in IDLE. If start and ld are both high, start wins and ld is dropped.
  - RDA: A <= R[rn]; → RDB.
  - RDB: B <= R[rm]; → EXEC.
  - EXEC: C <= alu_out and Z_flag <= alu_z; → WB.
  - WB: done=1. If wb_en, R[rd] <= C. → IDLE.
- start and ld asserted outside IDLE are ignored. No queuing is performed.
- Ain, Bin and ALUop are combinational from A, B and the command registers.
  - They are required valid only in EXEC.
  - In other states they follow the current register contents.
- Shifter behaviour:
  - LSL1 drops B[15].
  - LSR1 inserts 0 at bit 15.
  - ASR1 replicates B[15].
  - All arithmetic is modulo 2^16; no carry or overflow is produced.
- C and Z_flag change only in EXEC and otherwise hold their values.
- rn, rm and rd may be equal to one another; reads see values from before the op.

## Timing
- Start is sampled at edge t0. The sequence that follows:
  - Edge t0+1 loads A.
  - Edge t0+2 loads B.
  - Edge t0+3 loads C and Z_flag.
  - done is high for exactly the cycle between t0+3 and t0+4.
  - Writeback happens at t0+4.
  - ready returns after t0+4.
- Minimum spacing between accepted starts is 5 cycles.
- No RAW hazard exists: the earliest next start is sampled at t0+5, and its read happens at t0+6, after the writeback.
- ld write latency is 1 cycle. The value is visible to a start sampled on the following edge.
- Reset values:
  - state IDLE, ready=1, done=0.
  - R0–R7 = 0, A = B = C = 0, Z_flag = 0.
  - Command registers = 0, so Ain = Bin = 0 and ALUop = 00.
- Reset asserted mid-operation aborts immediately and asynchronously. No writeback or done occurs, and all outputs take their reset values.

## Test plan
- ADD: ld R0=5, R1=7; start op=00 rn=0 rm=1 rd=2 wb_en=1 → done at t0+3, C=12, Z_flag=0. A follow-up op with asel=1, rm=2, op=00 returns C=12.
- SUB with shift: R3=10, R4=3; op=01, shift=01 → Bin=6, C=4, Z_flag=0.
- AND with immediate: R5=15; op=10, bsel=1, imm5=5'b01100 → Bin=12, C=12.
- MVN with ASR: R7=16'h8000; op=11, shift=11 → Bin=16'hC000, C=16'h3FFF.
- Zero flag and no writeback: R6=45; op=01 rn=6 rm=6 rd=6 wb_en=0 → C=0, Z_flag=1. A subsequent asel=1 ADD of rm=6 returns 45.
- Busy and reset:
  - start and ld pulsed during RDB are ignored: no state change, and the targeted register is unchanged.
  - reset asserted in EXEC → ready=1, done=0, C=0, Z_flag=0 immediately. R[rd] is not written, and no done pulse follows.
